// File: rtl/craft_rc_gen.sv
// craft_rc_gen: round-constant generator for the CRAFT block cipher.
// Two free-running LFSRs (4-bit "a", 3-bit "b") plus a round counter.
// The output rc = {a, 1'b0, b} is taken straight from the registers.
// After NUM_ROUNDS constants the generator reloads its seeds so every
// block starts from 8'h11.
// Optional feature macro: CRAFT_RC_STALL_EN adds an "en" input that
// gates all state updates. Reset always takes precedence over en.
module craft_rc_gen #(
  parameter int NUM_ROUNDS = 32
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CRAFT_RC_STALL_EN
  input  logic       en,
`endif
  output logic [7:0] rc
);

  localparam int CW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ROUNDS - 1);

  localparam logic [3:0] A_SEED = 4'b0001;
  localparam logic [2:0] B_SEED = 3'b001;

  logic [3:0]    a;
  logic [2:0]    b;
  logic [CW-1:0] cnt;

  logic [3:0]    a_next;
  logic [2:0]    b_next;
  logic [CW-1:0] cnt_next;
  logic          adv;
  logic          wrap;

`ifdef CRAFT_RC_STALL_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  assign wrap = (cnt == LAST_CNT);

  // Next-state: advance both LFSRs, or reload seeds at the end of a block.
  // Both seeds are nonzero, so the all-zero lock-up state is unreachable.
  always_comb begin
    a_next   = {a[0] ^ a[1], a[3:1]};
    b_next   = {b[0] ^ b[1], b[2:1]};
    cnt_next = cnt + 1'b1;
    if (wrap) begin
      a_next   = A_SEED;
      b_next   = B_SEED;
      cnt_next = '0;
    end
  end

  // State registers: async reload on reset, otherwise update when advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a   <= A_SEED;
      b   <= B_SEED;
      cnt <= '0;
    end else if (adv) begin
      a   <= a_next;
      b   <= b_next;
      cnt <= cnt_next;
    end
  end

  // Output: bit 3 is a fixed zero between the two LFSR fields.
  always_comb begin
    rc = {a, 1'b0, b};
  end

endmodule

// File: tb/tb_craft_rc_gen.sv
// Directed testbench for craft_rc_gen (NUM_ROUNDS=32 and NUM_ROUNDS=1).
module tb_craft_rc_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rc;
  logic [7:0] rc_one;
`ifdef CRAFT_RC_STALL_EN
  logic       en = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] EXP [16] = '{
    8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
    8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14
  };

  always #5 clk = ~clk;

  craft_rc_gen #(.NUM_ROUNDS(32)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CRAFT_RC_STALL_EN
    .en (en),
`endif
    .rc (rc)
  );

  craft_rc_gen #(.NUM_ROUNDS(1)) dut_one (
    .clk(clk),
    .rst(rst),
`ifdef CRAFT_RC_STALL_EN
    .en (en),
`endif
    .rc (rc_one)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_async: rc=%h expected=%h", rc, 8'h11);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_hold: rc=%h expected=%h", rc, 8'h11);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rc !== EXP[k]) begin
        n_fail++;
        $display("FAIL reset_release idx%0d: rc=%h expected=%h", k, rc, EXP[k]);
      end
    end
  endtask

  task automatic test_sequence();
    do_reset();
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (rc !== EXP[k]) begin
        n_fail++;
        $display("FAIL sequence idx%0d: rc=%h expected=%h", k, rc, EXP[k]);
      end
      n_checks++;
      if (rc[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL bit3_zero idx%0d: rc=%h bit3 expected=0", k, rc);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h12) begin
      n_fail++;
      $display("FAIL wrap idx30: rc=%h expected=%h", rc, 8'h12);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h85) begin
      n_fail++;
      $display("FAIL wrap idx31: rc=%h expected=%h", rc, 8'h85);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL wrap to_seed: rc=%h expected=%h", rc, 8'h11);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h84) begin
      n_fail++;
      $display("FAIL wrap after_seed: rc=%h expected=%h", rc, 8'h84);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'hD5) begin
      n_fail++;
      $display("FAIL async_pre idx10: rc=%h expected=%h", rc, 8'hD5);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL async_assert: rc=%h expected=%h", rc, 8'h11);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL async_release idx0: rc=%h expected=%h", rc, 8'h11);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rc !== EXP[k]) begin
        n_fail++;
        $display("FAIL async_restart idx%0d: rc=%h expected=%h", k, rc, EXP[k]);
      end
    end
  endtask

  task automatic test_single_round();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rc_one !== 8'h11) begin
        n_fail++;
        $display("FAIL single_round cyc%0d: rc=%h expected=%h", k, rc_one, 8'h11);
      end
    end
  endtask

`ifdef CRAFT_RC_STALL_EN
  task automatic test_stall();
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h25) begin
      n_fail++;
      $display("FAIL stall_pre: rc=%h expected=%h", rc, 8'h25);
    end
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rc !== 8'h25) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: rc=%h expected=%h", k, rc, 8'h25);
      end
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rc !== 8'h96) begin
      n_fail++;
      $display("FAIL stall_resume: rc=%h expected=%h", rc, 8'h96);
    end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rc !== 8'h11) begin
      n_fail++;
      $display("FAIL stall_reset_override: rc=%h expected=%h", rc, 8'h11);
    end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_async_reset();
    test_single_round();
`ifdef CRAFT_RC_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
